// File: rtl/muldiv_seq_unit_pkg.sv
// muldiv_pkg: shared definitions for the sequential multiply/divide unit.
// Holds the FSM state encoding, the op encoding and the two's-complement
// magnitude helper used for operand conditioning and result sign fix-up.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Widest value the helper can negate; covers the 2*WIDTH product for
  // operand widths up to 64 bits.
  localparam int MAX_W = 128;

  // Returns |value| when value is negative, value otherwise. Callers
  // zero-extend into MAX_W and truncate the result back to their own width,
  // so the low bits are the correct two's-complement negation. Applied to
  // the most negative number it yields the unsigned magnitude 2^(w-1).
  // The same operation serves as a conditional negate of results.
  function automatic logic [MAX_W-1:0] twos_mag(input logic [MAX_W-1:0] value,
                                                input logic negative);
    return negative ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// muldiv_seq_unit_if: request/response bundle between the control FSM and
// the multiply/divide unit.
//   start, op, is_signed, a, b : request, driven by the master
//   busy, done, div0, hi, lo   : status and results, driven by the slave
interface muldiv_seq_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic             op;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, is_signed, a, b,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, is_signed, a, b,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/muldiv_seq_unit_div_step.sv
// muldiv_div_step: one combinational restoring-division iteration.
//   rem_in  : current partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : next partial remainder
//   q_bit   : quotient bit produced by this iteration
module muldiv_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder needs one extra bit; whichever value is kept is
  // below the divisor, so it always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = WIDTH'(q_bit ? diff : shifted);
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative WIDTH-bit signed/unsigned multiply and divide.
// Ports:
//   clock    : system clock, rising edge
//   RESET_in : asynchronous active-high reset, aborts any operation
//   bus      : muldiv_seq_unit_if slave (start/op/is_signed/a/b in,
//              busy/done/div0/hi/lo out)
// Operands are reduced to magnitudes on start, iterated for WIDTH cycles in
// RUN (shift-add multiply or restoring divide), sign-corrected in FIX and
// reported with a one-cycle done pulse. Divide by zero skips straight to
// DONE with div0 set and leaves hi/lo untouched.
// Optional macro MULDIV_EARLY_TERM_EN: multiply leaves RUN as soon as the
// remaining multiplier magnitude is zero (at least one RUN cycle).
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clock,
  input logic         RESET_in,
  muldiv_seq_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_r, neg_res, neg_rem, div0_flag;
  logic [PW-1:0]    acc, opnd_a;
  logic [WIDTH-1:0] opnd_b, hi_r, lo_r;

  logic             start_div0, sign_a, sign_b, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b, step_rem, fix_quot, fix_rem;
  logic             step_q;
  logic [PW-1:0]    fix_prod;
  logic             busy, done, div0;

  // Request decode and operand conditioning. Divide keeps the dividend in
  // the low half of acc and the partial remainder in the high half, so the
  // quotient shifts in from the bottom as the dividend shifts out the top.
  always_comb begin
    start_div0 = bus.start && (bus.op == OP_DIV) && (bus.b == '0);
    sign_a     = bus.is_signed & bus.a[WIDTH-1];
    sign_b     = bus.is_signed & bus.b[WIDTH-1];
    mag_a      = WIDTH'(twos_mag(MAX_W'(bus.a), sign_a));
    mag_b      = WIDTH'(twos_mag(MAX_W'(bus.b), sign_b));
    fix_prod   = PW'(twos_mag(MAX_W'(acc), neg_res));
    fix_quot   = WIDTH'(twos_mag(MAX_W'(acc[WIDTH-1:0]), neg_res));
    fix_rem    = WIDTH'(twos_mag(MAX_W'(acc[PW-1:WIDTH]), neg_rem));
`ifdef MULDIV_EARLY_TERM_EN
    last_iter  = (cnt == LAST_CNT) ||
                 ((op_r == OP_MULT) && (opnd_b[WIDTH-1:1] == '0));
`else
    last_iter  = (cnt == LAST_CNT);
`endif
  end

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc[PW-1:WIDTH]),
    .bit_in  (acc[WIDTH-1]),
    .divisor (opnd_b),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = start_div0 ? DONE : RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs depend on state only, so done/div0 cannot leak out of DONE.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    div0 = done && div0_flag;
  end

  // Datapath: operand latch in IDLE, one iteration per RUN cycle, sign fix
  // and result register in FIX. hi/lo are written nowhere else.
  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) begin
      cnt       <= '0;
      op_r      <= OP_MULT;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div0_flag <= 1'b0;
      acc       <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            div0_flag <= start_div0;
            if (!start_div0) begin
              op_r    <= bus.op;
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
              cnt     <= '0;
              opnd_b  <= mag_b;
              if (bus.op == OP_DIV) begin
                acc    <= {{WIDTH{1'b0}}, mag_a};
                opnd_a <= '0;
              end else begin
                acc    <= '0;
                opnd_a <= {{WIDTH{1'b0}}, mag_a};
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r == OP_MULT) begin
            if (opnd_b[0]) acc <= acc + opnd_a;
            opnd_a <= opnd_a << 1;
            opnd_b <= opnd_b >> 1;
          end else begin
            acc <= {step_rem, acc[WIDTH-2:0], step_q};
          end
        end
        FIX: begin
          if (op_r == OP_MULT) begin
            hi_r <= fix_prod[PW-1:WIDTH];
            lo_r <= fix_prod[WIDTH-1:0];
          end else begin
            hi_r <= fix_rem;
            lo_r <= fix_quot;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.div0 = div0;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: self-checking bench for muldiv_seq_unit (WIDTH=32).
// Directed cases plus randomized operations, each compared against a
// plain-arithmetic reference of the product, quotient/remainder and latency.
module tb_muldiv_seq_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic RESET_in;
  int   compareCount  = 0;
  int   mismatchCount = 0;
  logic [WIDTH-1:0] modelHi, modelLo;

  muldiv_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_seq_unit #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .RESET_in (RESET_in),
    .bus      (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts the comparison, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result {hi, lo} from ordinary integer arithmetic.
  function automatic logic [63:0] refResult(input logic opIn, input logic sgnIn,
                                            input logic [WIDTH-1:0] aIn,
                                            input logic [WIDTH-1:0] bIn);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, qv, rv;
    sa = longint'($signed(aIn));
    sb = longint'($signed(bIn));
    ua = {32'b0, aIn};
    ub = {32'b0, bIn};
    if (opIn == OP_MULT) begin
      if (sgnIn) return 64'(sa * sb);
      return ua * ub;
    end
    if (sgnIn) begin
      q  = sa / sb;
      r  = sa % sb;
      qv = 64'(q);
      rv = 64'(r);
    end else begin
      qv = ua / ub;
      rv = ua % ub;
    end
    return {rv[31:0], qv[31:0]};
  endfunction

  // Cycle (counting the start cycle as 0) in which done is expected.
  function automatic int refLatency(input logic opIn, input logic sgnIn,
                                    input logic [WIDTH-1:0] bIn);
    int iters;
    if (opIn == OP_DIV && bIn == '0) return 1;
    iters = WIDTH;
`ifdef MULDIV_EARLY_TERM_EN
    if (opIn == OP_MULT) begin
      logic [WIDTH-1:0] mag;
      mag   = (sgnIn && bIn[WIDTH-1]) ? (~bIn + 32'd1) : bIn;
      iters = 1;
      for (int i = 0; i < WIDTH; i++) if (mag[i]) iters = i + 1;
    end
`else
    if (sgnIn) iters = WIDTH;
`endif
    return iters + 2;
  endfunction

  // Issues one operation and checks latency, busy, hold behaviour and
  // results. A nonzero interfereAt raises a second start in that cycle.
  task automatic applyStimulus(input logic opIn, input logic sgnIn,
                               input logic [WIDTH-1:0] aIn,
                               input logic [WIDTH-1:0] bIn,
                               input int interfereAt);
    logic [63:0] expRes;
    logic        expDiv0;
    int          expCycle, doneCycle, busyLow, strayDiv0;
    expDiv0  = (opIn == OP_DIV) && (bIn == '0);
    expRes   = expDiv0 ? {modelHi, modelLo} : refResult(opIn, sgnIn, aIn, bIn);
    expCycle = refLatency(opIn, sgnIn, bIn);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op        = opIn;
    bus.is_signed = sgnIn;
    bus.a         = aIn;
    bus.b         = bIn;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.op        = 1'($urandom_range(0, 1));
    bus.is_signed = 1'($urandom_range(0, 1));
    doneCycle = -1;
    busyLow   = 0;
    strayDiv0 = 0;
    for (int k = 1; k <= 200 && doneCycle < 0; k++) begin
      @(negedge clock);
      bus.start = (k == interfereAt);
      if (k == interfereAt) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (!bus.busy) busyLow++;
      if (bus.div0 && !bus.done) strayDiv0++;
      if (k == 1 || (k == expCycle - 1 && expCycle > 2)) begin
        checkOutput("hold_hi", 64'(bus.hi), 64'(modelHi));
        checkOutput("hold_lo", 64'(bus.lo), 64'(modelLo));
      end
      if (bus.done) begin
        doneCycle = k;
        checkOutput("hi", 64'(bus.hi), 64'(expRes[63:32]));
        checkOutput("lo", 64'(bus.lo), 64'(expRes[31:0]));
        checkOutput("div0", 64'(bus.div0), 64'(expDiv0));
      end
    end
    bus.start = 1'b0;
    checkOutput("done_cycle", 64'(doneCycle), 64'(expCycle));
    checkOutput("busy_low_cycles", 64'(busyLow), 64'd0);
    checkOutput("stray_div0", 64'(strayDiv0), 64'd0);
    @(negedge clock);
    checkOutput("idle_after", 64'({bus.busy, bus.done, bus.div0}), 64'd0);
    modelHi = expRes[63:32];
    modelLo = expRes[31:0];
  endtask

  // Starts a full-length multiply and resets it in cycle 10.
  task automatic applyAbort();
    int doneSeen;
    doneSeen = 0;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op        = OP_MULT;
    bus.is_signed = 1'b0;
    bus.a         = 32'h1234_5679;
    bus.b         = 32'h8000_0001;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      if (bus.done) doneSeen++;
    end
    @(negedge clock);
    RESET_in = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    checkOutput("abort_hi", 64'(bus.hi), 64'd0);
    checkOutput("abort_lo", 64'(bus.lo), 64'd0);
    @(negedge clock);
    RESET_in = 1'b0;
    modelHi  = '0;
    modelLo  = '0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
  endtask

  // Operand picker biased toward the arithmetic corner values.
  function automatic logic [WIDTH-1:0] pickValue();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0001;
      3:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    RESET_in      = 1'b1;
    bus.start     = 1'b0;
    bus.op        = OP_MULT;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    modelHi       = '0;
    modelLo       = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_status", 64'({bus.busy, bus.done, bus.div0}), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    RESET_in = 1'b0;
    @(negedge clock);

    applyStimulus(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7, 0);
    applyStimulus(OP_MULT, 1'b0, 32'd5, 32'd3, 0);
    applyStimulus(OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(OP_DIV,  1'b0, 32'd100, 32'd7, 0);
    applyStimulus(OP_DIV,  1'b0, 32'h0000_0451, 32'h0000_0020, 0);
    applyStimulus(OP_DIV,  1'b1, 32'hDEAD_BEEF, 32'd0, 0);
    applyStimulus(OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(OP_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    applyStimulus(OP_DIV,  1'b0, 32'hCAFE_F00D, 32'h0000_1234, 5);
    applyStimulus(OP_MULT, 1'b0, 32'h0001_0003, 32'hF000_0000, 2);

    applyAbort();
    applyStimulus(OP_MULT, 1'b1, 32'h7654_3210, 32'hC000_0001, 0);

    for (int i = 0; i < 40; i++) begin
      logic opR, sgnR;
      logic [WIDTH-1:0] aR, bR;
      opR  = 1'($urandom_range(0, 1));
      sgnR = 1'($urandom_range(0, 1));
      aR   = pickValue();
      bR   = pickValue();
      if ($urandom_range(0, 7) == 0) bR = '0;
      applyStimulus(opR, sgnR, aR, bR, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
